// File: rtl/uart_transmitter_if.sv
// Host-side handshake bundle for the UART transmitter.
// Carries the byte and start strobe in, and the serial line, busy and done back out.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       start;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output data_in,
    output start,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  start,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: LSB first, idle-high line, one byte per start strobe.
// The frame is exactly 10*CLKS_PER_BIT cycles long, and done pulses as the stop bit ends.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic           clk,
  input  logic           reset,
  uart_transmitter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             period_end;

  assign period_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = period_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (bus.start) begin
          shift_d   = bus.data_in;
          bit_idx_d = '0;
          busy_d    = 1'b1;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (period_end) begin
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (period_end) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // The next bit is already sitting one place up, so drive it before shifting.
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (period_end) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CLKS_PER_BIT=4: it checks the line, busy and done every cycle
// against a frame model built from the byte sent, and it rebuilds each byte by sampling the line mid-bit.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int CNT_W = 3;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;

  uart_transmitter_if bus ();

  uart_transmitter #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Counts every cycle in which done is high, so a stretched or duplicated pulse shows up.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic s);
    bus.data_in = d;
    bus.start   = s;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic e_tx, input logic e_busy, input logic e_done);
    check({tag, ".tx"},   32'(bus.tx),   32'(e_tx));
    check({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
    check({tag, ".done"}, 32'(bus.done), 32'(e_done));
  endtask

  // Called one step after the accepting edge E. Ends at E+40 (done cycle), or at the edge after reset.
  task automatic checkFrame(input string tag, input logic [7:0] d, input int inj_t,
                            input logic [7:0] inj_d, input int rst_t);
    logic [9:0] bits;
    logic [7:0] rx;
    bits = {1'b1, d, 1'b0};
    rx   = '0;
    for (int t = 0; t < FRAME; t++) begin
      checkOutput($sformatf("%s.t%0d", tag, t), bits[t / CPB], 1'b1, 1'b0);
      if ((t % CPB) == CPB / 2 && t >= CPB && t < 9 * CPB) rx[t / CPB - 1] = bus.tx;
      if (t == inj_t - 1) applyStimulus(inj_d, 1'b1);
      if (t == inj_t) applyStimulus(8'h00, 1'b0);
      if (t == rst_t - 1) begin
        reset = 1'b1;
        step();
        checkOutput($sformatf("%s.reset", tag), 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        return;
      end
      step();
    end
    checkOutput($sformatf("%s.end", tag), 1'b1, 1'b0, 1'b1);
    check($sformatf("%s.rx", tag), 32'(rx), 32'(d));
  endtask

  initial begin
    int dc;
    applyStimulus(8'h00, 1'b0);

    // 1. Reset, then a quiet idle line.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    checkOutput("reset", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0);
    end

    // Start together with reset: reset wins and nothing leaves.
    reset = 1'b1;
    applyStimulus(8'hA5, 1'b1);
    step();
    reset = 1'b0;
    applyStimulus(8'h00, 1'b0);
    checkOutput("rst_start", 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("rst_start_after", 1'b1, 1'b0, 1'b0);

    // 2. Single frame 0xA5.
    applyStimulus(8'hA5, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0);
    checkFrame("a5", 8'hA5, -10, 8'h00, -10);
    step();
    checkOutput("a5.after", 1'b1, 1'b0, 1'b0);
    check("a5.done_count", 32'(done_count), 32'd1);

    // 3. All-zero and all-one payloads.
    applyStimulus(8'h00, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0);
    checkFrame("x00", 8'h00, -10, 8'h00, -10);
    step();
    applyStimulus(8'hFF, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0);
    checkFrame("xff", 8'hFF, -10, 8'h00, -10);
    step();
    check("x00ff.done_count", 32'(done_count), 32'd3);

    // 4. A start strobe during a frame is ignored.
    applyStimulus(8'h3C, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0);
    checkFrame("x3c", 8'h3C, 12, 8'h99, -10);
    step();
    checkOutput("x3c.after", 1'b1, 1'b0, 1'b0);
    repeat (CPB) step();
    checkOutput("x3c.quiet", 1'b1, 1'b0, 1'b0);
    check("x3c.done_count", 32'(done_count), 32'd4);

    // 5. Reset mid-data abandons the frame without done, then a clean frame follows.
    applyStimulus(8'h3C, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0);
    checkFrame("abort", 8'h3C, -10, 8'h00, 17);
    dc = done_count;
    repeat (FRAME) step();
    checkOutput("abort.quiet", 1'b1, 1'b0, 1'b0);
    check("abort.done_count", 32'(done_count), 32'(dc));
    applyStimulus(8'h5A, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0);
    checkFrame("x5a", 8'h5A, -10, 8'h00, -10);
    step();
    check("x5a.done_count", 32'(done_count), 32'(dc + 1));

    // 6. start held high: frames every FRAME+1 cycles.
    applyStimulus(8'hC3, 1'b1);
    step();
    for (int f = 0; f < 3; f++) begin
      checkFrame($sformatf("b2b%0d", f), 8'hC3, -10, 8'h00, -10);
      step();
    end
    applyStimulus(8'h00, 1'b0);
    checkFrame("b2b3", 8'hC3, -10, 8'h00, -10);
    step();
    checkOutput("b2b.after", 1'b1, 1'b0, 1'b0);
    check("b2b.done_count", 32'(done_count), 32'(dc + 5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
